hssim_window: RTL and testbench
===============================

HSSIM_WINDOW -- requirements
Module: hssim_window

Interface
REQ-001 SHALL expose the following parameters, one per line (name, default, meaning):
- PIXELS_PER_BEAT, 16, lanes per beat.
- INPUT_WIDTH, 8, bits per pixel.
- WIN_BEATS, 4, beats per decision window (power of two, 1..16).
- NUMR_BIT_WIDTH, 36, numerator accumulator width.
- DENR_BIT_WIDTH, 36, denominator accumulator width.
- C1, 6, stabilising constant.
- OUT_MODE, 0, 0 = selected pixel, 1 = decision mask.

REQ-002 SHALL expose the following ports, one per line (name, direction, width, meaning). The block has one clock; reset is asynchronous and active-high.
- clk, input, 1, rising-edge clock.
- areset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block accepts beat.
- in_last, input, 1, final beat of frame, closes window early.
- old_map, input, INPUT_WIDTH*PIXELS_PER_BEAT, previous fused pixels.
- avg_map, input, INPUT_WIDTH*PIXELS_PER_BEAT, reference average pixels.
- new_map, input, INPUT_WIDTH*PIXELS_PER_BEAT, candidate pixels.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts beat.
- out_last, output, 1, last beat of a window closed by in_last.
- del_out, output, INPUT_WIDTH*PIXELS_PER_BEAT, per-lane result.

Function
REQ-003 SHALL transfer an input beat when in_valid and in_ready are both high at a rising edge, and an output beat when out_valid and out_ready are both high.

REQ-004 SHALL implement states ACCUM, MUL, CMP and DRAIN; in_ready SHALL be high only in ACCUM and never during reset.

REQ-005 In ACCUM, each accepted beat SHALL store old_map and new_map into a WIN_BEATS-deep buffer at the write index and increment the beat count.

REQ-006 Per lane and per accepted beat, the block SHALL add the following to the per-lane accumulators:
- num_o += 2*old*avg + C1
- den_o += old^2 + avg^2 + C1
- num_n += 2*new*avg + C1
- den_n += new^2 + avg^2 + C1

REQ-007 Accumulators SHALL saturate at all-ones of their width and never wrap.

REQ-008 The window SHALL close on the accepted beat where the count reaches WIN_BEATS or in_last is high, whichever occurs first; the state SHALL then go ACCUM -> MUL.

REQ-009 MUL SHALL register the products P_n = num_n*den_o and P_o = num_o*den_n, each NUMR_BIT_WIDTH+DENR_BIT_WIDTH bits unsigned; the state SHALL go MUL -> CMP after exactly one cycle.

REQ-010 CMP SHALL register a per-lane decision sel = (P_n > P_o); a tie SHALL select old; the state SHALL go CMP -> DRAIN after exactly one cycle.

REQ-011 out_valid SHALL first rise 3 cycles after the edge that accepted the closing beat.

REQ-012 DRAIN SHALL emit the buffered beats in input order, one per output transfer; the number of beats emitted SHALL equal the window count.

REQ-013 Per-lane del_out SHALL be new if sel is 1, else old, when OUT_MODE=0; when OUT_MODE=1 it SHALL be all-ones if sel is 1, else zero.

REQ-014 out_valid, del_out and out_last SHALL hold stable while out_valid is high and out_ready is low.

REQ-015 out_last SHALL be high only on the final drained beat of a window closed by in_last.

REQ-016 After the final drain transfer, the block SHALL clear the accumulators, count and indices and return to ACCUM; in_ready SHALL be high on the next cycle.

REQ-017 An in_last received with WIN_BEATS=1 or on a full-count beat SHALL close the window only once, with no duplicate window.

Reset
REQ-018 areset high SHALL asynchronously force: state ACCUM, in_ready=0, out_valid=0, out_last=0, del_out=0, all accumulators, counters and indices 0.

REQ-019 After areset deasserts, in_ready SHALL go high on the first rising edge.

REQ-020 A reset asserted mid-window or mid-DRAIN SHALL discard all buffered beats; no stale beat SHALL be emitted afterwards.

Structure
REQ-021 hssim_pkg SHALL hold the state encoding, the C1 default and a function for accumulator width sizing.

REQ-022 A sub-module hssim_lane SHALL contain one lane's four accumulators, products and decision, instantiated PIXELS_PER_BEAT times; the buffer and FSM SHALL reside in hssim_window.

Verification
REQ-023 WIN_BEATS=4, out_ready=1, old=avg=k, new=k+1 for k=10..13 -> 4 beats out, del_out lanes 10,11,12,13 (old selected), first out_valid 3 cycles after the 4th accept.

REQ-024 old=k, avg=new=k+50 for k=0..3 -> del_out lanes 50..53; OUT_MODE=1 -> 0xFF per lane.

REQ-025 in_last on the 2nd beat (old=avg=new=7) -> tie selects old, 2 beats out, out_last high on beat 2 only, in_ready low until drain completes.

REQ-026 out_ready random 50% over 400 beats -> no beat lost or duplicated, order preserved, del_out stable while stalled.

REQ-027 areset pulse during DRAIN after beat 1 of 4 -> out_valid 0 immediately, in_ready high on the first edge after release, next window output correct.

REQ-028 All inputs 255 with NUMR_BIT_WIDTH=DENR_BIT_WIDTH=18 -> accumulators saturate at 262143; tie selects old.

Source files
------------

// File: rtl/hssim_pkg.sv
// Shared state encoding, default constant and width helpers for the hssim window datapath.
package hssim_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        MUL   = 2'd1,
        CMP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int C1_DEFAULT = 6;

    // Two squared pixels need 2w+1 bits; two more bits leave room for the stabilising constant.
    function automatic int inc_width(input int input_width);
        return 2 * input_width + 3;
    endfunction

    // Adder width that can never wrap before the saturation compare.
    function automatic int sum_width(input int acc_width, input int inc_w);
        return ((acc_width > inc_w) ? acc_width : inc_w) + 1;
    endfunction

endpackage

// File: rtl/hssim_window_if.sv
// Beat-stream bundle: input maps with valid/ready/last, and the selected output beat.
interface hssim_window_if #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8
);
    localparam int DATA_W = PIXELS_PER_BEAT * INPUT_WIDTH;

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] old_map;
    logic [DATA_W-1:0] avg_map;
    logic [DATA_W-1:0] new_map;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DATA_W-1:0] del_out;

    modport master (
        output in_valid, in_last, old_map, avg_map, new_map, out_ready,
        input  in_ready, out_valid, out_last, del_out
    );

    modport slave (
        input  in_valid, in_last, old_map, avg_map, new_map, out_ready,
        output in_ready, out_valid, out_last, del_out
    );
endinterface

// File: rtl/hssim_lane.sv
// One lane: saturating similarity accumulators, cross-multiplied products and the
// registered old-versus-new decision.
module hssim_lane
    import hssim_pkg::*;
#(
    parameter int INPUT_WIDTH    = 8,
    parameter int NUMR_BIT_WIDTH = 36,
    parameter int DENR_BIT_WIDTH = 36,
    parameter int C1             = C1_DEFAULT
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   clear,
    input  logic                   acc_en,
    input  logic                   mul_en,
    input  logic                   cmp_en,
    input  logic [INPUT_WIDTH-1:0] old_px,
    input  logic [INPUT_WIDTH-1:0] avg_px,
    input  logic [INPUT_WIDTH-1:0] new_px,
    output logic                   sel
);
    localparam int INC_W  = inc_width(INPUT_WIDTH);
    localparam int NSUM_W = sum_width(NUMR_BIT_WIDTH, INC_W);
    localparam int DSUM_W = sum_width(DENR_BIT_WIDTH, INC_W);
    localparam int PROD_W = NUMR_BIT_WIDTH + DENR_BIT_WIDTH;
    localparam logic [NUMR_BIT_WIDTH-1:0] NUM_MAX = '1;
    localparam logic [DENR_BIT_WIDTH-1:0] DEN_MAX = '1;

    logic [INC_W-1:0] o, a, n, k;
    logic [INC_W-1:0] inc_num_o, inc_den_o, inc_num_n, inc_den_n;
    logic [NUMR_BIT_WIDTH-1:0] num_o_q, num_n_q, num_o_d, num_n_d;
    logic [DENR_BIT_WIDTH-1:0] den_o_q, den_n_q, den_o_d, den_n_d;
    logic [NSUM_W-1:0] sum_num_o, sum_num_n;
    logic [DSUM_W-1:0] sum_den_o, sum_den_n;
    logic [PROD_W-1:0] prod_n_q, prod_o_q;
    logic              sel_q;

    assign o = INC_W'(old_px);
    assign a = INC_W'(avg_px);
    assign n = INC_W'(new_px);
    assign k = INC_W'(C1);

    assign inc_num_o = ((o * a) << 1) + k;
    assign inc_den_o = (o * o) + (a * a) + k;
    assign inc_num_n = ((n * a) << 1) + k;
    assign inc_den_n = (n * n) + (a * a) + k;

    assign sum_num_o = NSUM_W'(num_o_q) + NSUM_W'(inc_num_o);
    assign sum_num_n = NSUM_W'(num_n_q) + NSUM_W'(inc_num_n);
    assign sum_den_o = DSUM_W'(den_o_q) + DSUM_W'(inc_den_o);
    assign sum_den_n = DSUM_W'(den_n_q) + DSUM_W'(inc_den_n);

    // Clamp at all-ones instead of wrapping, so a long bright window keeps its ordering.
    assign num_o_d = (sum_num_o > NSUM_W'(NUM_MAX)) ? NUM_MAX : sum_num_o[NUMR_BIT_WIDTH-1:0];
    assign num_n_d = (sum_num_n > NSUM_W'(NUM_MAX)) ? NUM_MAX : sum_num_n[NUMR_BIT_WIDTH-1:0];
    assign den_o_d = (sum_den_o > DSUM_W'(DEN_MAX)) ? DEN_MAX : sum_den_o[DENR_BIT_WIDTH-1:0];
    assign den_n_d = (sum_den_n > DSUM_W'(DEN_MAX)) ? DEN_MAX : sum_den_n[DENR_BIT_WIDTH-1:0];

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            num_o_q  <= '0;
            den_o_q  <= '0;
            num_n_q  <= '0;
            den_n_q  <= '0;
            prod_n_q <= '0;
            prod_o_q <= '0;
            sel_q    <= 1'b0;
        end else if (clear) begin
            num_o_q  <= '0;
            den_o_q  <= '0;
            num_n_q  <= '0;
            den_n_q  <= '0;
            prod_n_q <= '0;
            prod_o_q <= '0;
            sel_q    <= 1'b0;
        end else begin
            if (acc_en) begin
                num_o_q <= num_o_d;
                den_o_q <= den_o_d;
                num_n_q <= num_n_d;
                den_n_q <= den_n_d;
            end
            if (mul_en) begin
                prod_n_q <= PROD_W'(num_n_q) * PROD_W'(den_o_q);
                prod_o_q <= PROD_W'(num_o_q) * PROD_W'(den_n_q);
            end
            if (cmp_en) begin
                sel_q <= (prod_n_q > prod_o_q);
            end
        end
    end

    assign sel = sel_q;
endmodule

// File: rtl/hssim_window.sv
// Windowed similarity selector: buffers up to WIN_BEATS beats, decides per lane whether
// the candidate beats beat the previous ones, then replays the window with that choice.
module hssim_window
    import hssim_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8,
    parameter int WIN_BEATS       = 4,
    parameter int NUMR_BIT_WIDTH  = 36,
    parameter int DENR_BIT_WIDTH  = 36,
    parameter int C1              = C1_DEFAULT,
    parameter int OUT_MODE        = 0
) (
    input  logic          clk,
    input  logic          areset,
    hssim_window_if.slave bus
);
    localparam int DATA_W = PIXELS_PER_BEAT * INPUT_WIDTH;
    localparam int CNT_W  = $clog2(WIN_BEATS + 1);
    localparam int IDX_W  = (WIN_BEATS > 1) ? $clog2(WIN_BEATS) : 1;

    state_t                     state_q, state_d;
    logic                       armed_q;
    logic [CNT_W-1:0]           count_q, rd_q;
    logic                       last_win_q;
    logic                       out_valid_q, out_last_q;
    logic [DATA_W-1:0]          del_q, del_next;
    logic [DATA_W-1:0]          old_buf [WIN_BEATS];
    logic [DATA_W-1:0]          new_buf [WIN_BEATS];
    logic [DATA_W-1:0]          rd_old, rd_new;
    logic [PIXELS_PER_BEAT-1:0] sel;
    logic                       in_ready, accept_in, close_win, out_fire, load, done;
    logic [IDX_W-1:0]           wr_idx, rd_idx;

    // armed_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = armed_q && (state_q == ACCUM);
    assign accept_in = bus.in_valid && in_ready;
    assign close_win = accept_in && (bus.in_last || (count_q == CNT_W'(WIN_BEATS - 1)));
    assign out_fire  = out_valid_q && bus.out_ready;
    assign wr_idx    = IDX_W'(count_q);
    assign rd_idx    = IDX_W'(rd_q);
    assign rd_old    = old_buf[rd_idx];
    assign rd_new    = new_buf[rd_idx];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ACCUM: if (close_win) state_d = MUL;
            MUL:   state_d = CMP;
            CMP:   state_d = DRAIN;
            DRAIN: begin
                load = (rd_q < count_q) && (!out_valid_q || bus.out_ready);
                done = (rd_q == count_q) && out_fire;
                if (done) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            armed_q     <= 1'b0;
            count_q     <= '0;
            rd_q        <= '0;
            last_win_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            del_q       <= '0;
        end else begin
            armed_q <= 1'b1;
            if (accept_in) begin
                count_q <= count_q + CNT_W'(1);
                if (close_win) last_win_q <= bus.in_last;
            end
            if (load) begin
                rd_q        <= rd_q + CNT_W'(1);
                out_valid_q <= 1'b1;
                out_last_q  <= last_win_q && (rd_q == count_q - CNT_W'(1));
                del_q       <= del_next;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (done) begin
                count_q    <= '0;
                rd_q       <= '0;
                last_win_q <= 1'b0;
            end
        end
    end

    // NOTE: the pixel buffer is deliberately not reset; the beat count gates every read,
    // so contents left over from an aborted window are never emitted.
    always_ff @(posedge clk) begin
        if (accept_in) begin
            old_buf[wr_idx] <= bus.old_map;
            new_buf[wr_idx] <= bus.new_map;
        end
    end

    for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_lane
        hssim_lane #(
            .INPUT_WIDTH    (INPUT_WIDTH),
            .NUMR_BIT_WIDTH (NUMR_BIT_WIDTH),
            .DENR_BIT_WIDTH (DENR_BIT_WIDTH),
            .C1             (C1)
        ) u_lane (
            .clk    (clk),
            .areset (areset),
            .clear  (done),
            .acc_en (accept_in),
            .mul_en (state_q == MUL),
            .cmp_en (state_q == CMP),
            .old_px (bus.old_map[i*INPUT_WIDTH +: INPUT_WIDTH]),
            .avg_px (bus.avg_map[i*INPUT_WIDTH +: INPUT_WIDTH]),
            .new_px (bus.new_map[i*INPUT_WIDTH +: INPUT_WIDTH]),
            .sel    (sel[i])
        );

        assign del_next[i*INPUT_WIDTH +: INPUT_WIDTH] = (OUT_MODE == 1)
            ? {INPUT_WIDTH{sel[i]}}
            : (sel[i] ? rd_new[i*INPUT_WIDTH +: INPUT_WIDTH] : rd_old[i*INPUT_WIDTH +: INPUT_WIDTH]);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.del_out   = del_q;
endmodule

// File: tb/tb_hssim_window.sv
// Directed bench for hssim_window: a default-mode instance and a mask-mode 18-bit instance
// share one stimulus stream.
module tb_hssim_window;
    localparam int PPB = 16;
    localparam int IW  = 8;
    localparam int DW  = PPB * IW;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [DW-1:0] old_m = '0, avg_m = '0, new_m = '0;

    int total = 0, bad = 0, cyc = 0;
    int got, rdy_err, extra, latency, close_cyc;
    logic rdy_after;
    logic [DW-1:0] s_old [8], s_avg [8], s_new [8];
    logic [DW-1:0] cap_a [$], cap_b [$];
    logic cap_last [$];
    logic [35:0] snap_b [4];
    logic [35:0] snap_a_num_o;
    logic [DW-1:0] cur_old, cur_avg, cur_new, cur_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hssim_window_if #(.PIXELS_PER_BEAT(PPB), .INPUT_WIDTH(IW)) ifa ();
    hssim_window_if #(.PIXELS_PER_BEAT(PPB), .INPUT_WIDTH(IW)) ifb ();

    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifa.in_last = in_last;    assign ifb.in_last = in_last;
    assign ifa.old_map = old_m;      assign ifb.old_map = old_m;
    assign ifa.avg_map = avg_m;      assign ifb.avg_map = avg_m;
    assign ifa.new_map = new_m;      assign ifb.new_map = new_m;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    hssim_window #(.WIN_BEATS(4)) u_dut_a (.clk(clk), .areset(areset), .bus(ifa.slave));
    hssim_window #(.WIN_BEATS(4), .NUMR_BIT_WIDTH(18), .DENR_BIT_WIDTH(18), .OUT_MODE(1))
        u_dut_b (.clk(clk), .areset(areset), .bus(ifb.slave));

    function automatic logic [DW-1:0] fill(input int base, input int step);
        logic [DW-1:0] m;
        for (int l = 0; l < PPB; l++) m[l*IW +: IW] = IW'(base + step * l);
        return m;
    endfunction

    // Sends n beats from s_* with out_ready high and captures every emitted beat.
    task automatic run_window(input int n, input bit use_last, input int abort_after);
        int sent = 0, guard = 0;
        bit seen = 0;
        got = 0; rdy_err = 0; extra = 0; latency = -1; close_cyc = 0; rdy_after = 1'b0;
        cap_a.delete(); cap_b.delete(); cap_last.delete();
        out_ready = 1'b1;
        while (got < n && guard < 100) begin
            @(negedge clk);
            guard++;
            if (sent == n && ifa.in_ready) rdy_err++;
            if (sent < n) begin
                in_valid = 1'b1;
                old_m = s_old[sent]; avg_m = s_avg[sent]; new_m = s_new[sent];
                in_last = use_last && (sent == n - 1);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
            if (in_valid && ifa.in_ready) begin
                sent++;
                if (sent == n) close_cyc = cyc + 1;
            end
            if (ifa.out_valid) begin
                if (!seen) begin
                    seen = 1;
                    latency = cyc - close_cyc;
                    snap_b[0] = 36'(u_dut_b.g_lane[0].u_lane.num_o_q);
                    snap_b[1] = 36'(u_dut_b.g_lane[0].u_lane.den_o_q);
                    snap_b[2] = 36'(u_dut_b.g_lane[0].u_lane.num_n_q);
                    snap_b[3] = 36'(u_dut_b.g_lane[0].u_lane.den_n_q);
                    snap_a_num_o = u_dut_a.g_lane[15].u_lane.num_o_q;
                end
                cap_a.push_back(ifa.del_out);
                cap_b.push_back(ifb.del_out);
                cap_last.push_back(ifa.out_last);
                got++;
                if (abort_after > 0 && got == abort_after) break;
            end
        end
        if (abort_after == 0) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last = 1'b0;
                if (i == 0) rdy_after = ifa.in_ready;
                if (ifa.out_valid) extra++;
            end
        end
    endtask

    task automatic check_window(input string name, input int n, input bit use_last, input bit want_new);
        total++;
        if (got !== n) begin bad++; $display("FAIL %s beats: got %0d want %0d", name, got, n); end
        total++;
        if (latency !== 3) begin bad++; $display("FAIL %s latency: got %0d want 3", name, latency); end
        for (int k = 0; k < n; k++) begin
            total++;
            if (k >= cap_a.size() || cap_a[k] !== (want_new ? s_new[k] : s_old[k])) begin
                bad++;
                $display("FAIL %s del_out[%0d]: got %h want %h", name, k,
                         (k < cap_a.size()) ? cap_a[k] : '0, want_new ? s_new[k] : s_old[k]);
            end
            total++;
            if (k >= cap_last.size() || cap_last[k] !== (use_last && k == n - 1)) begin
                bad++;
                $display("FAIL %s out_last[%0d]: got %b want %b", name, k,
                         (k < cap_last.size()) ? cap_last[k] : 1'bx, use_last && k == n - 1);
            end
        end
        total++;
        if (rdy_err !== 0) begin bad++; $display("FAIL %s in_ready during window: %0d high cycles, want 0", name, rdy_err); end
        total++;
        if (rdy_after !== 1'b1 || extra !== 0) begin
            bad++;
            $display("FAIL %s after drain: in_ready %b want 1, extra beats %0d want 0", name, rdy_after, extra);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b0 || ifa.out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset ctrl: in_ready %b out_valid %b out_last %b want 000", ifa.in_ready, ifa.out_valid, ifa.out_last);
        end
        total++;
        if (ifa.del_out !== '0) begin bad++; $display("FAIL reset del_out: got %h want 0", ifa.del_out); end
        @(negedge clk);
        areset = 1'b0;
        #1;
        total++;
        if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL release in_ready before edge: got %b want 0", ifa.in_ready); end
        @(posedge clk);
        #1;
        total++;
        if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL release in_ready after edge: got %b want 1", ifa.in_ready); end
    endtask

    task automatic test_old_select();
        for (int k = 0; k < 4; k++) begin
            s_old[k] = fill(10 + k, 1); s_avg[k] = s_old[k]; s_new[k] = fill(11 + k, 1);
        end
        run_window(4, 1'b0, 0);
        check_window("old_select", 4, 1'b0, 1'b0);
    endtask

    task automatic test_new_select();
        for (int k = 0; k < 4; k++) begin
            s_old[k] = fill(k, 1); s_avg[k] = fill(50 + k, 1); s_new[k] = s_avg[k];
        end
        run_window(4, 1'b0, 0);
        check_window("new_select", 4, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= cap_b.size() || cap_b[k] !== {DW{1'b1}}) begin
                bad++; $display("FAIL mask_new[%0d]: got %h want all ones", k, (k < cap_b.size()) ? cap_b[k] : '0);
            end
        end
    endtask

    task automatic test_in_last();
        for (int k = 0; k < 2; k++) begin
            s_old[k] = fill(7, 0); s_avg[k] = s_old[k]; s_new[k] = s_old[k];
        end
        run_window(2, 1'b1, 0);
        check_window("in_last", 2, 1'b1, 1'b0);
        total++;
        if (cap_b.size() != 2 || cap_b[0] !== '0 || cap_b[1] !== '0) begin
            bad++; $display("FAIL tie_mask: got %0d beats, first %h, want 2 zero beats", cap_b.size(), (cap_b.size() > 0) ? cap_b[0] : '1);
        end
    endtask

    task automatic test_last_full();
        for (int k = 0; k < 4; k++) begin
            s_old[k] = fill(100 + 3 * k, 2); s_avg[k] = s_old[k]; s_new[k] = fill(101 + 3 * k, 2);
        end
        run_window(4, 1'b1, 0);
        check_window("last_full", 4, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 4; k++) begin
            s_old[k] = fill(255, 0); s_avg[k] = s_old[k]; s_new[k] = s_old[k];
        end
        run_window(4, 1'b0, 0);
        check_window("saturate", 4, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (snap_b[j] !== 36'd262143) begin bad++; $display("FAIL sat_acc[%0d]: got %0d want 262143", j, snap_b[j]); end
        end
        total++;
        if (snap_a_num_o !== 36'd520224) begin bad++; $display("FAIL wide_acc: got %0d want 520224", snap_a_num_o); end
        total++;
        if (cap_b.size() != 4 || cap_b[3] !== '0) begin bad++; $display("FAIL sat_mask: got %0d beats want 4 zero beats", cap_b.size()); end
    endtask

    task automatic test_reset_drain();
        int stale = 0;
        for (int k = 0; k < 4; k++) begin
            s_old[k] = fill(20 + k, 1); s_avg[k] = s_old[k]; s_new[k] = fill(21 + k, 1);
        end
        run_window(4, 1'b0, 1);
        @(posedge clk);
        #2 areset = 1'b1;
        #1;
        total++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.out_last !== 1'b0) begin
            bad++;
            $display("FAIL mid_drain reset: out_valid %b in_ready %b out_last %b want 000", ifa.out_valid, ifa.in_ready, ifa.out_last);
        end
        @(negedge clk);
        areset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset in_ready: got %b want 1", ifa.in_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifa.out_valid) stale++;
        end
        total++;
        if (stale !== 0) begin bad++; $display("FAIL stale beats: got %0d want 0", stale); end
        for (int k = 0; k < 4; k++) begin
            s_old[k] = fill(3 * k, 1); s_avg[k] = fill(60 + k, 2); s_new[k] = s_avg[k];
        end
        run_window(4, 1'b0, 0);
        check_window("after_reset", 4, 1'b0, 1'b1);
    endtask

    // Even windows: old=avg, new=old+1 (old wins). Odd windows: avg=new (new wins or ties).
    task automatic gen_beat(input int widx);
        for (int l = 0; l < PPB; l++) begin
            int r;
            r = $urandom_range(0, 254);
            if (widx % 2 == 0) begin
                cur_old[l*IW +: IW] = IW'(r); cur_avg[l*IW +: IW] = IW'(r); cur_new[l*IW +: IW] = IW'(r + 1);
                cur_exp[l*IW +: IW] = IW'(r);
            end else begin
                cur_old[l*IW +: IW] = IW'($urandom_range(0, 255));
                cur_avg[l*IW +: IW] = IW'(r); cur_new[l*IW +: IW] = IW'(r);
                cur_exp[l*IW +: IW] = IW'(r);
            end
        end
    endtask

    task automatic test_random_stall();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] prev_del = '0, e;
        logic prev_last = 1'b0;
        bit prev_stall = 0;
        int sent = 0, rcv = 0, mism = 0, stall_err = 0, lost = 0, guard = 0;
        gen_beat(0);
        while (rcv < 400 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (prev_stall && (ifa.out_valid !== 1'b1 || ifa.del_out !== prev_del || ifa.out_last !== prev_last))
                stall_err++;
            out_ready = ($urandom_range(0, 1) == 1);
            in_valid = (sent < 400);
            in_last = 1'b0;
            old_m = cur_old; avg_m = cur_avg; new_m = cur_new;
            if (in_valid && ifa.in_ready) begin
                exp_q.push_back(cur_exp);
                sent++;
                gen_beat(sent / 4);
            end
            if (ifa.out_valid && out_ready) begin
                if (exp_q.size() == 0) lost++;
                else begin
                    e = exp_q.pop_front();
                    if (ifa.del_out !== e) mism++;
                end
                rcv++;
            end
            prev_stall = ifa.out_valid && !out_ready;
            prev_del = ifa.del_out;
            prev_last = ifa.out_last;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (rcv !== 400 || sent !== 400 || exp_q.size() != 0 || lost !== 0) begin
            bad++;
            $display("FAIL stream count: sent %0d received %0d pending %0d unexpected %0d, want 400/400/0/0", sent, rcv, exp_q.size(), lost);
        end
        total++;
        if (mism !== 0) begin bad++; $display("FAIL stream order: %0d wrong beats, want 0", mism); end
        total++;
        if (stall_err !== 0) begin bad++; $display("FAIL stall hold: %0d unstable cycles, want 0", stall_err); end
    endtask

    initial begin
        test_reset();
        test_old_select();
        test_new_select();
        test_in_last();
        test_last_full();
        test_saturate();
        test_reset_drain();
        test_random_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
